// File: rtl/p08_layer_ctrl_if.sv
// Pixel/config bundle between the host side and the layer controller.
// The master modport drives beam position and config writes; the slave is the controller.
interface p08_layer_ctrl_if;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        visible;
    logic        frame_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        map_en;
    logic        debug_en;
    logic [5:0]  bg_rgb;
    logic        cfg_pending;
    logic [7:0]  frame_count;

    modport master (
        output hpos, vpos, visible, frame_start, cfg_valid, cfg_addr, cfg_data,
        input  cfg_ready, map_en, debug_en, bg_rgb, cfg_pending, frame_count
    );

    modport slave (
        input  hpos, vpos, visible, frame_start, cfg_valid, cfg_addr, cfg_data,
        output cfg_ready, map_en, debug_en, bg_rgb, cfg_pending, frame_count
    );
endinterface

// File: rtl/p08_layer_ctrl.sv
// Frame-synchronous layer controller for the raybox-zero pixel mux.
// Host writes go to shadow registers; the whole set is copied to the active registers in a
// single COMMIT cycle after frame_start, so a layer never changes mid-frame. Per-pixel
// outputs are registered and derived from the active registers only.
module p08_layer_ctrl #(
    parameter int unsigned MAP_SIZE   = 64,
    parameter int unsigned HORIZON    = 240,
    parameter int unsigned DEBUG_ROWS = 8,
    parameter int unsigned BLINK_BIT  = 4
) (
    input logic              clk,
    input logic              reset,
    p08_layer_ctrl_if.slave  bus_io
);

    localparam logic [5:0] SkyReset   = 6'b010101;
    localparam logic [5:0] FloorReset = 6'b101010;

    typedef enum logic [1:0] {
        StIdle,
        StPending,
        StCommit
    } state_e;

    state_e      state_q;
    logic        cfg_ready_q;
    logic        cfg_pending_q;
    logic [7:0]  frame_count_q;

    // Shadow (host-visible) configuration.
    logic [2:0]  sh_flags_q, sh_flags_d;
    logic [9:0]  sh_map_x_q, sh_map_x_d;
    logic [9:0]  sh_map_y_q, sh_map_y_d;
    logic [5:0]  sh_sky_q, sh_sky_d;
    logic [5:0]  sh_floor_q, sh_floor_d;

    // Active configuration seen by the pixel path.
    logic [2:0]  act_flags_q;
    logic [9:0]  act_map_x_q;
    logic [9:0]  act_map_y_q;
    logic [5:0]  act_sky_q;
    logic [5:0]  act_floor_q;

    // Registered pixel outputs.
    logic        map_en_q, map_en_d;
    logic        debug_en_q, debug_en_d;
    logic [5:0]  bg_rgb_q, bg_rgb_d;

    logic        cfg_accept;
    logic        debug_on;
    logic        map_on;
    logic        blink;
    logic [10:0] hpos_w;
    logic [10:0] vpos_w;
    logic [10:0] win_x_lo;
    logic [10:0] win_x_hi;
    logic [10:0] win_y_lo;
    logic [10:0] win_y_hi;
    logic        in_win;

    assign cfg_accept = bus_io.cfg_valid & cfg_ready_q;

    assign debug_on = act_flags_q[0];
    assign map_on   = act_flags_q[1];
    assign blink    = act_flags_q[2];

    // Shadow write decode; an accepted write lands at the accepting edge.
    always_comb begin
        sh_flags_d = sh_flags_q;
        sh_map_x_d = sh_map_x_q;
        sh_map_y_d = sh_map_y_q;
        sh_sky_d   = sh_sky_q;
        sh_floor_d = sh_floor_q;
        if (cfg_accept) begin
            unique case (bus_io.cfg_addr)
                2'd0: sh_flags_d = bus_io.cfg_data[2:0];
                2'd1: sh_map_x_d = bus_io.cfg_data[9:0];
                2'd2: sh_map_y_d = bus_io.cfg_data[9:0];
                2'd3: begin
                    sh_sky_d   = bus_io.cfg_data[11:6];
                    sh_floor_d = bus_io.cfg_data[5:0];
                end
                default: ;
            endcase
        end
    end

    // Shadow registers; reset discards any uncommitted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_flags_q <= 3'b000;
            sh_map_x_q <= 10'd0;
            sh_map_y_q <= 10'd0;
            sh_sky_q   <= SkyReset;
            sh_floor_q <= FloorReset;
        end else begin
            sh_flags_q <= sh_flags_d;
            sh_map_x_q <= sh_map_x_d;
            sh_map_y_q <= sh_map_y_d;
            sh_sky_q   <= sh_sky_d;
            sh_floor_q <= sh_floor_d;
        end
    end

    // Commit FSM with registered cfg_ready/cfg_pending; COMMIT copies shadow to active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cfg_ready_q   <= 1'b1;
            cfg_pending_q <= 1'b0;
            act_flags_q   <= 3'b000;
            act_map_x_q   <= 10'd0;
            act_map_y_q   <= 10'd0;
            act_sky_q     <= SkyReset;
            act_floor_q   <= FloorReset;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A frame_start coinciding with the first write does not commit it.
                    if (cfg_accept) begin
                        state_q       <= StPending;
                        cfg_pending_q <= 1'b1;
                    end
                end
                StPending: begin
                    if (bus_io.frame_start) begin
                        state_q     <= StCommit;
                        cfg_ready_q <= 1'b0;
                    end
                end
                StCommit: begin
                    act_flags_q   <= sh_flags_q;
                    act_map_x_q   <= sh_map_x_q;
                    act_map_y_q   <= sh_map_y_q;
                    act_sky_q     <= sh_sky_q;
                    act_floor_q   <= sh_floor_q;
                    state_q       <= StIdle;
                    cfg_ready_q   <= 1'b1;
                    cfg_pending_q <= 1'b0;
                end
                default: begin
                    state_q       <= StIdle;
                    cfg_ready_q   <= 1'b1;
                    cfg_pending_q <= 1'b0;
                end
            endcase
        end
    end

    // Frame counter advances on every frame_start, independent of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_q <= 8'd0;
        end else if (bus_io.frame_start) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    // Window bounds are 11 bits wide so a window near 1023 clips instead of wrapping.
    assign hpos_w   = {1'b0, bus_io.hpos};
    assign vpos_w   = {1'b0, bus_io.vpos};
    assign win_x_lo = {1'b0, act_map_x_q};
    assign win_y_lo = {1'b0, act_map_y_q};
    assign win_x_hi = win_x_lo + 11'(MAP_SIZE);
    assign win_y_hi = win_y_lo + 11'(MAP_SIZE);
    assign in_win   = (hpos_w >= win_x_lo) && (hpos_w < win_x_hi) &&
                      (vpos_w >= win_y_lo) && (vpos_w < win_y_hi);

    // Per-pixel layer decisions from the active configuration.
    always_comb begin
        map_en_d   = bus_io.visible & map_on & in_win & (~blink | frame_count_q[BLINK_BIT]);
        debug_en_d = bus_io.visible & debug_on & (bus_io.vpos < 10'(DEBUG_ROWS));
        bg_rgb_d   = 6'd0;
        if (bus_io.visible) begin
            bg_rgb_d = (bus_io.vpos < 10'(HORIZON)) ? act_sky_q : act_floor_q;
        end
    end

    // One-cycle output pipeline to the mux.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_en_q   <= 1'b0;
            debug_en_q <= 1'b0;
            bg_rgb_q   <= 6'd0;
        end else begin
            map_en_q   <= map_en_d;
            debug_en_q <= debug_en_d;
            bg_rgb_q   <= bg_rgb_d;
        end
    end

    assign bus_io.cfg_ready   = cfg_ready_q;
    assign bus_io.cfg_pending = cfg_pending_q;
    assign bus_io.frame_count = frame_count_q;
    assign bus_io.map_en      = map_en_q;
    assign bus_io.debug_en    = debug_en_q;
    assign bus_io.bg_rgb      = bg_rgb_q;

endmodule

// File: tb/tb_p08_layer_ctrl.sv
// Directed bench for p08_layer_ctrl: a reference model of the shadow/active configuration
// predicts each pixel result, which is queued when the pixel is driven and checked when
// the registered output appears one cycle later.
module tb_p08_layer_ctrl;

    logic clk = 1'b0;
    logic reset;

    p08_layer_ctrl_if bus ();

    p08_layer_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       map_en;
        logic       debug_en;
        logic [5:0] bg;
    } pix_t;

    pix_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: shadow and active configuration plus frame counter.
    logic [2:0] s_flags, m_flags;
    logic [9:0] s_mx, m_mx, s_my, m_my;
    logic [5:0] s_sky, m_sky, s_floor, m_floor;
    logic [7:0] m_fc;

    task automatic model_reset();
        s_flags = 3'b000; m_flags = 3'b000;
        s_mx = 10'd0; m_mx = 10'd0; s_my = 10'd0; m_my = 10'd0;
        s_sky = 6'b010101; m_sky = 6'b010101;
        s_floor = 6'b101010; m_floor = 6'b101010;
        m_fc = 8'd0;
        sb_q.delete();
    endtask

    task automatic model_commit();
        m_flags = s_flags; m_mx = s_mx; m_my = s_my; m_sky = s_sky; m_floor = s_floor;
    endtask

    function automatic logic exp_map(input int h, input int v, input logic vis);
        logic inwin;
        inwin = (h >= int'(m_mx)) && (h < int'(m_mx) + 64) &&
                (v >= int'(m_my)) && (v < int'(m_my) + 64);
        return vis && m_flags[1] && inwin && (!m_flags[2] || m_fc[4]);
    endfunction

    function automatic logic exp_dbg(input int v, input logic vis);
        return vis && m_flags[0] && (v < 8);
    endfunction

    function automatic logic [5:0] exp_bg(input int v, input logic vis);
        if (!vis) return 6'd0;
        return (v < 240) ? m_sky : m_floor;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int h, input int v, input logic vis);
        pix_t e;
        bus.hpos    = 10'(h);
        bus.vpos    = 10'(v);
        bus.visible = vis;
        e.map_en    = exp_map(h, v, vis);
        e.debug_en  = exp_dbg(v, vis);
        e.bg        = exp_bg(v, vis);
        sb_q.push_back(e);
        tick();
        e = sb_q.pop_front();
        check($sformatf("map_en h%0d v%0d vis%0d", h, v, vis), 32'(bus.map_en), 32'(e.map_en));
        check($sformatf("debug_en h%0d v%0d vis%0d", h, v, vis), 32'(bus.debug_en),
              32'(e.debug_en));
        check($sformatf("bg_rgb h%0d v%0d vis%0d", h, v, vis), 32'(bus.bg_rgb), 32'(e.bg));
    endtask

    // Config write, optionally coinciding with frame_start.
    task automatic wr(input logic [1:0] addr, input logic [11:0] data, input logic fs);
        check("cfg_ready before write", 32'(bus.cfg_ready), 32'd1);
        bus.cfg_valid   = 1'b1;
        bus.cfg_addr    = addr;
        bus.cfg_data    = data;
        bus.frame_start = fs;
        tick();
        bus.cfg_valid   = 1'b0;
        bus.frame_start = 1'b0;
        unique case (addr)
            2'd0: s_flags = data[2:0];
            2'd1: s_mx = data[9:0];
            2'd2: s_my = data[9:0];
            2'd3: begin s_sky = data[11:6]; s_floor = data[5:0]; end
            default: ;
        endcase
        if (fs) m_fc = m_fc + 8'd1;
        check("cfg_pending after write", 32'(bus.cfg_pending), 32'd1);
    endtask

    // Called right after the edge that entered COMMIT.
    task automatic finish_commit();
        check("cfg_ready in commit", 32'(bus.cfg_ready), 32'd0);
        check("cfg_pending in commit", 32'(bus.cfg_pending), 32'd1);
        tick();
        check("cfg_ready after commit", 32'(bus.cfg_ready), 32'd1);
        check("cfg_pending after commit", 32'(bus.cfg_pending), 32'd0);
        model_commit();
    endtask

    task automatic frame_pulse();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        m_fc = m_fc + 8'd1;
        check("frame_count", 32'(bus.frame_count), 32'(m_fc));
    endtask

    task automatic commit();
        frame_pulse();
        finish_commit();
    endtask

    initial begin
        reset           = 1'b1;
        bus.hpos        = 10'd0;
        bus.vpos        = 10'd0;
        bus.visible     = 1'b0;
        bus.frame_start = 1'b0;
        bus.cfg_valid   = 1'b0;
        bus.cfg_addr    = 2'd0;
        bus.cfg_data    = 12'd0;
        model_reset();
        tick();
        tick();

        // Reset state.
        check("reset map_en", 32'(bus.map_en), 32'd0);
        check("reset debug_en", 32'(bus.debug_en), 32'd0);
        check("reset bg_rgb", 32'(bus.bg_rgb), 32'd0);
        check("reset cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("reset cfg_pending", 32'(bus.cfg_pending), 32'd0);
        check("reset frame_count", 32'(bus.frame_count), 32'd0);
        reset = 1'b0;

        // Default sky/floor after release.
        pixel(5, 10, 1'b1);
        pixel(5, 239, 1'b1);
        pixel(5, 240, 1'b1);
        pixel(5, 10, 1'b0);

        // Map window staged, then committed at frame_start.
        wr(2'd1, 12'd100, 1'b0);
        wr(2'd2, 12'd50, 1'b0);
        wr(2'd0, 12'b010, 1'b0);
        pixel(100, 50, 1'b1);
        check("pending before frame", 32'(bus.cfg_pending), 32'd1);
        commit();
        pixel(99, 50, 1'b1);
        pixel(100, 50, 1'b1);
        pixel(163, 113, 1'b1);
        pixel(164, 50, 1'b1);
        pixel(100, 49, 1'b1);
        pixel(100, 114, 1'b1);
        pixel(130, 80, 1'b0);

        // Write on the frame_start edge while PENDING joins that commit.
        wr(2'd0, 12'b010, 1'b0);
        wr(2'd3, 12'hFC0, 1'b1);
        finish_commit();
        pixel(5, 10, 1'b1);
        pixel(5, 300, 1'b1);

        // Write with frame_start from IDLE waits for the next frame.
        wr(2'd3, 12'h5AB, 1'b1);
        check("cfg_ready after idle write+fs", 32'(bus.cfg_ready), 32'd1);
        pixel(5, 10, 1'b1);
        commit();
        pixel(5, 10, 1'b1);
        pixel(5, 300, 1'b1);

        // Window near the right edge is clipped, not wrapped.
        wr(2'd1, 12'd1000, 1'b0);
        wr(2'd2, 12'd0, 1'b0);
        commit();
        pixel(999, 0, 1'b1);
        pixel(1000, 0, 1'b1);
        pixel(1023, 5, 1'b1);
        pixel(0, 5, 1'b1);
        pixel(39, 5, 1'b1);
        pixel(20, 63, 1'b1);

        // Blink gated by frame_count bit 4, then frame_count wrap.
        wr(2'd0, 12'b110, 1'b0);
        commit();
        for (int i = 0; i < 34; i++) begin
            frame_pulse();
            pixel(1010, 5, 1'b1);
        end
        while (m_fc != 8'd255) frame_pulse();
        pixel(1010, 5, 1'b1);
        frame_pulse();
        pixel(1010, 5, 1'b1);

        // Debug strip gated by visible.
        wr(2'd0, 12'b001, 1'b0);
        commit();
        pixel(5, 3, 1'b0);
        pixel(5, 3, 1'b1);
        pixel(5, 7, 1'b1);
        pixel(5, 8, 1'b1);

        // Asynchronous reset mid-frame while a write is pending.
        bus.hpos    = 10'd5;
        bus.vpos    = 10'd3;
        bus.visible = 1'b1;
        wr(2'd3, 12'hFFF, 1'b0);
        reset = 1'b1;
        #1;
        check("async reset debug_en", 32'(bus.debug_en), 32'd0);
        check("async reset bg_rgb", 32'(bus.bg_rgb), 32'd0);
        check("async reset map_en", 32'(bus.map_en), 32'd0);
        check("async reset cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("async reset cfg_pending", 32'(bus.cfg_pending), 32'd0);
        check("async reset frame_count", 32'(bus.frame_count), 32'd0);
        tick();
        reset = 1'b0;
        model_reset();
        pixel(5, 10, 1'b1);
        frame_pulse();
        pixel(5, 10, 1'b1);
        pixel(5, 3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
